// File: rtl/bytebeat_pkg.sv
// Shared types and helpers for the bytebeat mixer.
package bytebeat_pkg;

    // Per-voice formula selector codes
    typedef enum logic [1:0] {
        FORM_CHIME = 2'd0,
        FORM_PULSE = 2'd1,
        FORM_XOR   = 2'd2,
        FORM_SAW   = 2'd3
    } formula_e;

    localparam int unsigned SampleW = 8;

    // Right shift that turns the voice sum into an average
    function automatic int unsigned mix_shift(input int unsigned num_voices);
        return (num_voices <= 1) ? 0 : $clog2(num_voices);
    endfunction

endpackage

// File: rtl/bytebeat_voice.sv
// One bytebeat voice: formula evaluator, mute gate and voice register.
module bytebeat_voice
    import bytebeat_pkg::*;
#(
    parameter int unsigned T_WIDTH = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [T_WIDTH-1:0] t,
    input  logic [1:0]         sel,
    input  logic               mute,
    output logic [SampleW-1:0] voice
);

    logic [SampleW-1:0] form_val;
    logic [SampleW-1:0] voice_q;

    // Evaluate the selected formula at full width, keep the low byte
    always_comb begin
        form_val = '0;
        unique case (formula_e'(sel))
            FORM_CHIME: form_val = SampleW'(t * (((t >> 12) | (t >> 8)) &
                                                 (T_WIDTH'(63) & (t >> 4))));
            FORM_PULSE: form_val = SampleW'(t * ((t >> 5) | (t >> 8)));
            FORM_XOR:   form_val = SampleW'(((t * T_WIDTH'(5)) & (t >> 7)) |
                                            ((t * T_WIDTH'(3)) & (t >> 10)));
            FORM_SAW:   form_val = SampleW'(t);
            default:    form_val = '0;
        endcase
    end

    // Voice register loads once per tick; a muted voice contributes zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            voice_q <= '0;
        end else if (load) begin
            voice_q <= mute ? '0 : form_val;
        end
    end

    assign voice = voice_q;

endmodule

// File: rtl/bytebeat_mixer.sv
// Multi-voice bytebeat engine: prescaler, time counter, voices, averaging mix
// and PWM DAC. Define BYTEBEAT_PWM_EN to build the PWM; otherwise pwm_out is 0.
module bytebeat_mixer
    import bytebeat_pkg::*;
#(
    parameter int unsigned T_WIDTH    = 24,
    parameter int unsigned NUM_VOICES = 2,
    parameter int unsigned SAMPLE_DIV = 1250
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    restart,
    input  logic [2*NUM_VOICES-1:0] formula_sel,
    input  logic [NUM_VOICES-1:0]   mute,
    output logic [SampleW-1:0]      sample,
    output logic                    sample_valid,
    output logic                    pwm_out
);

    localparam int unsigned Shift = mix_shift(NUM_VOICES);
    localparam int unsigned AccW  = SampleW + Shift;
    localparam int unsigned DivW  = $clog2(SAMPLE_DIV);

    logic [DivW-1:0]    div_cnt;
    logic [T_WIDTH-1:0] t;
    logic               tick;
    logic               tick_q;
    logic               voice_valid_q;
    logic [SampleW-1:0] voice_out [NUM_VOICES];
    logic [AccW-1:0]    acc;
    logic [SampleW-1:0] mix_d;
    logic [SampleW-1:0] sample_q;
    logic               sample_valid_q;

    // restart wins over a coincident tick
    assign tick = ena && !restart && (div_cnt == DivW'(SAMPLE_DIV - 1));

    // Prescaler and shared time counter; tick_q marks a freshly advanced t
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
            t       <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= tick;
            if (restart) begin
                div_cnt <= '0;
                t       <= '0;
            end else if (ena) begin
                if (tick) begin
                    div_cnt <= '0;
                    t       <= t + T_WIDTH'(1);
                end else begin
                    div_cnt <= div_cnt + DivW'(1);
                end
            end
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        bytebeat_voice #(
            .T_WIDTH(T_WIDTH)
        ) u_voice (
            .clk  (clk),
            .rst_n(rst_n),
            .load (tick_q),
            .t    (t),
            .sel  (formula_sel[2*v +: 2]),
            .mute (mute[v]),
            .voice(voice_out[v])
        );
    end

    // Sum voice bytes and divide by the voice count
    always_comb begin
        acc = '0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            acc = acc + AccW'(voice_out[v]);
        end
        mix_d = SampleW'(acc >> Shift);
    end

    // Voice-valid delay and mix/output register with its one-cycle strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            voice_valid_q  <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            voice_valid_q  <= tick_q;
            sample_valid_q <= voice_valid_q;
            if (voice_valid_q) begin
                sample_q <= mix_d;
            end
        end
    end

    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;

`ifdef BYTEBEAT_PWM_EN
    logic [7:0] pwm_cnt;
    logic       pwm_q;

    // Free-running 256-cycle PWM compared against the current sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            pwm_q   <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            pwm_q   <= (pwm_cnt < sample_q);
        end
    end

    assign pwm_out = pwm_q;
`else
    assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_bytebeat_mixer.sv
// Scoreboard bench for bytebeat_mixer with SAMPLE_DIV=4, NUM_VOICES=2, plus a
// T_WIDTH=8 instance for counter wrap.
module tb_bytebeat_mixer;

    localparam int unsigned SD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       restart;
    logic [3:0] formula_sel;
    logic [1:0] mute;
    logic [7:0] sample;
    logic       sample_valid;
    logic       pwm_out;

    logic       rst_w_n;
    logic [7:0] w_sample;
    logic       w_valid;
    logic       w_pwm;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int w_cnt = 0;

    typedef struct {
        logic [7:0] val;
        int         stamp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    bytebeat_mixer #(
        .T_WIDTH   (24),
        .NUM_VOICES(2),
        .SAMPLE_DIV(SD)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .restart     (restart),
        .formula_sel (formula_sel),
        .mute        (mute),
        .sample      (sample),
        .sample_valid(sample_valid),
        .pwm_out     (pwm_out)
    );

    bytebeat_mixer #(
        .T_WIDTH   (8),
        .NUM_VOICES(2),
        .SAMPLE_DIV(SD)
    ) u_wrap (
        .clk         (clk),
        .rst_n       (rst_w_n),
        .ena         (1'b1),
        .restart     (1'b0),
        .formula_sel (4'b1111),
        .mute        (2'b00),
        .sample      (w_sample),
        .sample_valid(w_valid),
        .pwm_out     (w_pwm)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] f_ref(input logic [1:0] c, input logic [23:0] t);
        logic [23:0] r;
        case (c)
            2'd0:    r = t * (((t >> 12) | (t >> 8)) & (24'd63 & (t >> 4)));
            2'd1:    r = t * ((t >> 5) | (t >> 8));
            2'd2:    r = ((t * 24'd5) & (t >> 7)) | ((t * 24'd3) & (t >> 10));
            default: r = t;
        endcase
        return r[7:0];
    endfunction

    function automatic logic [7:0] mix_ref(input logic [23:0] t);
        int s = 0;
        for (int v = 0; v < 2; v++) begin
            if (!mute[v]) s += int'(f_ref(formula_sel[2*v +: 2], t));
        end
        return 8'(s >> 1);
    endfunction

    // Reference model: prescaler and t; at the voice stage push the expected sample
    initial begin : model
        int          m_div;
        logic [23:0] m_t;
        bit          m_tick;
        bit          m_pend;
        exp_t        e;
        m_div  = 0;
        m_t    = '0;
        m_pend = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_div  = 0;
                m_t    = '0;
                m_pend = 1'b0;
                sb.delete();
            end else begin
                if (m_pend) begin
                    e.val   = mix_ref(m_t);
                    e.stamp = cyc + 1;
                    sb.push_back(e);
                end
                m_tick = ena && !restart && (m_div == SD - 1);
                m_pend = m_tick;
                if (restart) begin
                    m_t   = '0;
                    m_div = 0;
                end else if (ena) begin
                    if (m_tick) begin
                        m_div = 0;
                        m_t   = m_t + 24'd1;
                    end else begin
                        m_div++;
                    end
                end
            end
        end
    end

    // Monitor: every strobe must match the head of the scoreboard, on time
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sample_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL spurious_strobe: got sample %0d at cycle %0d, expected none",
                             sample, cyc);
                end else begin
                    e = sb.pop_front();
                    check("sb_sample", 32'(sample), 32'(e.val));
                    check("sb_strobe_cycle", cyc, e.stamp);
                end
            end else if (sb.size() > 0 && sb[0].stamp <= cyc) begin
                e = sb.pop_front();
                n_vec++;
                n_bad++;
                $display("FAIL missing_strobe: got none at cycle %0d, expected sample %0d",
                         cyc, e.val);
            end
        end
    end

    // Wrap instance: sawtooth must count up mod 256 at a fixed cadence
    initial begin : wrap_monitor
        logic [7:0] w_exp;
        int         last;
        w_exp = 8'd1;
        last  = -1;
        forever begin
            @(negedge clk);
            if (w_valid === 1'b1) begin
                check("wrap_sample", 32'(w_sample), 32'(w_exp));
                if (last >= 0) check("wrap_cadence", cyc - last, SD);
                last  = cyc;
                w_exp = w_exp + 8'd1;
                w_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for the next strobe; n counts negedges visited, including the strobe's
    task automatic wait_strobe(output logic [7:0] s, output int n);
        n = 0;
        s = 'x;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (sample_valid === 1'b1) begin
                s = sample;
                return;
            end
        end
        n_vec++;
        n_bad++;
        $display("FAIL strobe_timeout: got no strobe in %0d cycles, expected one", n);
    endtask

    initial begin : stimulus
        logic [7:0] s;
        logic [7:0] held;
        int         n;
        int         cnt;
        int         hi;
        int         guard;

        rst_n       = 1'b0;
        rst_w_n     = 1'b0;
        ena         = 1'b1;
        restart     = 1'b0;
        formula_sel = 4'b1111;
        mute        = 2'b00;

        repeat (5) begin
            @(negedge clk);
            check("rst_sample", 32'(sample), 0);
            check("rst_valid", 32'(sample_valid), 0);
            check("rst_pwm", 32'(pwm_out), 0);
        end
        step();
        rst_n   = 1'b1;
        rst_w_n = 1'b1;

        // First strobe lands in cycle 6, counting the release cycle as cycle 0
        wait_strobe(s, n);
        check("first_latency", n, SD + 3);
        check("first_sample", 32'(s), 1);

        for (int k = 2; k <= 9; k++) begin
            wait_strobe(s, n);
            check("saw_value", 32'(s), k);
            check("saw_period", n, SD);
        end

        // t=10 with voice 1 muted, then t=11 with both voices
        step();
        mute = 2'b10;
        wait_strobe(s, n);
        check("mute_avg", 32'(s), 5);
        step();
        mute = 2'b00;
        wait_strobe(s, n);
        check("unmute", 32'(s), 11);

        // Restart in a tick cycle: that tick is dropped, t restarts from 0
        step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        wait_strobe(s, n);
        check("restart_latency", n, SD + 3);
        check("restart_sample", 32'(s), 1);

        // Hold ena low: no strobes, sample holds
        step();
        ena  = 1'b0;
        held = sample;
        cnt  = 0;
        repeat (20) begin
            @(negedge clk);
            if (sample_valid === 1'b1) cnt++;
        end
        check("ena_no_strobe", cnt, 0);
        check("ena_hold", 32'(sample), 32'(held));
        step();
        ena = 1'b1;

        // Run the sawtooth up to 64, then freeze for the PWM duty check
        guard = 0;
        s     = 8'd0;
        while (s != 8'd64 && guard < 80) begin
            wait_strobe(s, n);
            guard++;
        end
        step();
        ena = 1'b0;
        check("pwm_level", 32'(sample), 64);
        repeat (4) step();
        hi = 0;
        repeat (256) begin
            @(negedge clk);
            if (pwm_out === 1'b1) hi++;
        end
`ifdef BYTEBEAT_PWM_EN
        check("pwm_duty", hi, 64);
`else
        check("pwm_off", hi, 0);
`endif

        // t=65: voice 0 code 2 gives 0, voice 1 code 1 gives 65*2=130 -> 65
        formula_sel = {2'd1, 2'd2};
        step();
        ena = 1'b1;
        wait_strobe(s, n);
        check("formula_mix", 32'(s), 65);
        repeat (200) wait_strobe(s, n);
        formula_sel = {2'd0, 2'd3};
        repeat (60) wait_strobe(s, n);

        guard = 0;
        while (w_cnt < 260 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("wrap_strobe_count_reached", 32'(w_cnt >= 260), 1);

        // Reset while a sample sits in the voice stage: no stale strobe
        step();
        step();
        step();
        rst_n = 1'b0;
        cnt   = 0;
        repeat (8) begin
            @(negedge clk);
            if (sample_valid !== 1'b0) cnt++;
        end
        check("midreset_no_strobe", cnt, 0);
        check("midreset_sample", 32'(sample), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
